packet_verdict_gate: RTL and testbench
======================================

// Module: packet_verdict_gate
// PURPOSE
//  Final stage of the drop path. Sits after the delay fifo and the windowing
//  checker: records one pass/drop verdict per packet seen on the undelayed
//  input stream, then applies it to the same packet leaving the delay fifo.
//  Dropped packets are removed whole (sop..eop); passed packets go out 1 cycle late.
//  Also keeps per-packet pass/drop counters and sticky error flags.
// PARAMETERS
//  DEPTH   16  verdict queue entries (power of 2, >=2); max packets in delay fifo
//  CNT_W   32  width of pass/drop packet counters
// PORTS
//  sys_clk        in   1        clock
//  reset          in   1        async reset, active-high
//  in             in   avln_st  undelayed stream (same stream fed to fifo input)
//  verdict_valid  in   1        1-cycle pulse: verdict for most recent packet
//  verdict_drop   in   1        1=drop that packet; sampled when verdict_valid
//  dly            in   avln_st  delayed stream from fifo output
//  out            out  avln_st  gated stream
//  drop_pulse     out  1        1 cycle, coincident with sop of a dropped packet slot
//  pass_count     out  CNT_W    packets forwarded (wraps)
//  drop_count     out  CNT_W    packets dropped (wraps)
//  overflow       out  1        sticky: in.sop with queue full
//  underflow      out  1        sticky: dly.sop with queue empty
// BEHAVIOUR
//  Reset: queue empty, tail_ok=0, gate state PASS, out all fields 0,
//   drop_pulse=0, counters 0, flags 0. Reset mid-packet discards all state.
//  Queue: DEPTH x 1-bit drop flags, rd/wr ptrs log2(DEPTH)+1 bits (wrap bit).
//  Push: in.valid & in.sop -> push entry 0 (pass); tail_ok<=1. Queue full ->
//   no push, overflow<=1, tail_ok<=0.
//  Mark: verdict_valid & tail_ok -> entry at wr_ptr-1 |= verdict_drop.
//   tail_ok=0 -> verdict ignored. Mark and push same cycle: mark hits the
//   entry that was tail before the push (pre-push ptr).
//  Pop: dly.valid & dly.sop -> head popped; decision = head flag, OR'd with
//   verdict_drop when same-cycle mark targets the head (bypass). Queue empty
//   -> decision = pass, underflow<=1. Push+pop same cycle on full queue:
//   push proceeds (occupancy unchanged), no overflow.
//  Gate FSM: PASS / DROP. At dly sop: decision drop -> DROP; pass -> PASS.
//   DROP held until dly.valid & dly.eop, then PASS. sop&eop same word: state
//   is PASS after it, but that word still gated by its own decision.
//   Gated word = current sop-word decision, else current state.
//  Output (1-cycle latency, registered): out.data <= dly.data every cycle;
//   out.valid/sop/eop <= dly fields & ~gated. Other avln_st fields follow dly.
//  drop_pulse <= dly.valid & dly.sop & decision_drop.
//  Counters: at dly sop, pass_count+1 or drop_count+1 (exactly one); wrap.
//  Flags clear only on reset.
// TESTING
//  1. 3 pkts in (4 words each), verdicts pass,drop,pass, dly 20 cycles later
//     -> out has pkts 1,3 only, 1 cycle late; pass=2 drop=1; 1 drop_pulse.
//  2. Non-IPv4 pkt (no verdict) -> forwarded; verdict_valid before any sop
//     -> ignored, no counter change.
//  3. DEPTH=4: 5 sops before any dly sop -> overflow=1 at 5th; later verdict
//     ignored; 5th pkt at dly -> underflow=1, passed.
//  4. Verdict drop in same cycle as head pop (1 entry) -> packet dropped via
//     bypass; verdict + in.sop same cycle -> marks older packet, new one pass.
//  5. 1-word pkts (sop&eop) alternating drop/pass back-to-back -> exact
//     alternation on out, no state leak between packets.
//  6. Assert reset mid DROP packet -> out.valid=0 next cycle, counters 0;
//     following pkt with pass verdict forwarded intact.

Source files
------------

// File: rtl/packet_verdict_gate.sv
// Verdict gate: queues one pass/drop flag per packet entering the delay fifo
// and applies it to the same packet as it leaves the fifo. Dropped packets
// are removed whole; passed words are forwarded one cycle late.

package avln_pkg;
    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        error;
        logic [31:0] data;
    } avln_st;
endpackage

module packet_verdict_gate
    import avln_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  avln_st           in,
    input  logic             verdict_valid,
    input  logic             verdict_drop,
    input  avln_st           dly,
    output avln_st           out,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             underflow
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {GATE_PASS, GATE_DROP} gate_t;

    logic [DEPTH-1:0] flags_reg;
    logic [DEPTH-1:0] flags_next;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic             tail_ok_reg;
    gate_t            state_reg;

    logic [PTR_W-1:0] fill;
    logic [PTR_W-1:0] tail_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             push_req;
    logic             pop_req;
    logic             q_empty;
    logic             q_full;
    logic             push_ok;
    logic             pop_ok;
    logic             mark;
    logic             bypass;
    logic             decision_drop;
    logic             gated;
    logic             unused_in;

    // Only the framing bits of the undelayed stream matter here.
    assign unused_in = &{1'b0, in.eop, in.empty, in.error, in.data};

    assign push_req = in.valid & in.sop;
    assign pop_req  = dly.valid & dly.sop;

    assign fill     = wr_ptr_reg - rd_ptr_reg;
    assign q_empty  = (fill == '0);
    assign q_full   = (fill == PTR_W'(DEPTH));
    assign tail_ptr = wr_ptr_reg - PTR_W'(1);
    assign wr_idx   = wr_ptr_reg[IDX_W-1:0];
    assign rd_idx   = rd_ptr_reg[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];

    // A pop on a full queue frees the slot the push needs in the same cycle.
    assign pop_ok  = pop_req & ~q_empty;
    assign push_ok = push_req & (~q_full | pop_req);

    // Verdicts always target the entry that was tail before any push this cycle.
    assign mark = verdict_valid & tail_ok_reg;

    // When the tail is also the head being popped, the late verdict is folded
    // straight into the decision instead of waiting for the flag write.
    assign bypass        = mark & verdict_drop & (tail_ptr == rd_ptr_reg);
    assign decision_drop = pop_ok & (flags_reg[rd_idx] | bypass);
    assign gated         = pop_req ? decision_drop : (state_reg == GATE_DROP);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign flags_next[gi] =
                (push_ok && wr_idx == IDX_W'(gi))  ? 1'b0 :
                (mark && tail_idx == IDX_W'(gi))   ? (flags_reg[gi] | verdict_drop) :
                flags_reg[gi];
        end
    endgenerate

    // Verdict flag storage: cleared on push, accumulates drop verdicts while tail.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            flags_reg <= '0;
        end else begin
            flags_reg <= flags_next;
        end
    end

    // Queue pointers, tail validity and sticky error flags.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            tail_ok_reg <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push_req) begin
                tail_ok_reg <= push_ok;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop_req && q_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Per-packet pass/drop counters, bumped once at each delayed sop.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            pass_count <= '0;
            drop_count <= '0;
        end else if (pop_req) begin
            if (decision_drop) begin
                drop_count <= drop_count + CNT_W'(1);
            end else begin
                pass_count <= pass_count + CNT_W'(1);
            end
        end
    end

    // Gate FSM with registered output stream and drop pulse.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_reg  <= GATE_PASS;
            out        <= '0;
            drop_pulse <= 1'b0;
        end else begin
            if (pop_req) begin
                state_reg <= (decision_drop && !dly.eop) ? GATE_DROP : GATE_PASS;
            end else if (dly.valid && dly.eop) begin
                state_reg <= GATE_PASS;
            end
            out       <= dly;
            out.valid <= dly.valid & ~gated;
            out.sop   <= dly.sop & ~gated;
            out.eop   <= dly.eop & ~gated;
            drop_pulse <= decision_drop;
        end
    end

endmodule

// File: tb/tb_packet_verdict_gate.sv
// Bench for packet_verdict_gate: a delay line stands in for the packet fifo,
// and a packet-level queue model predicts every output each cycle.

module tb_packet_verdict_gate;
    import avln_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    avln_st           in_w = '0;
    avln_st           dly_w = '0;
    avln_st           out_w;
    logic             verdict_valid = 1'b0;
    logic             verdict_drop = 1'b0;
    logic             drop_pulse;
    logic             overflow;
    logic             underflow;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] drop_count;

    packet_verdict_gate #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .sys_clk       (clk),
        .reset         (rst),
        .in            (in_w),
        .verdict_valid (verdict_valid),
        .verdict_drop  (verdict_drop),
        .dly           (dly_w),
        .out           (out_w),
        .drop_pulse    (drop_pulse),
        .pass_count    (pass_count),
        .drop_count    (drop_count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: one flag per packet in the fifo, oldest first.
    bit          mq[$];
    bit          m_tail_ok;
    bit          m_cur_drop;
    bit          m_ovf;
    bit          m_udf;
    bit          m_pulse;
    avln_st      m_out;
    int unsigned m_pass;
    int unsigned m_drop;
    int unsigned obs_pulses;
    int unsigned obs_sops;
    avln_st      dline[$];

    task automatic model_reset();
        mq.delete();
        m_tail_ok  = 0;
        m_cur_drop = 0;
        m_ovf      = 0;
        m_udf      = 0;
        m_pulse    = 0;
        m_out      = '0;
        m_pass     = 0;
        m_drop     = 0;
    endtask

    task automatic model_step(input avln_st iw, input bit vv, input bit vd, input avln_st d);
        bit push;
        bit pop;
        bit dec;
        bit gate;
        push = iw.valid && iw.sop;
        pop  = d.valid && d.sop;
        dec  = 0;
        // Verdict applies to the newest packet already queued.
        if (vv && m_tail_ok && mq.size() > 0)
            mq[mq.size()-1] = mq[mq.size()-1] | vd;
        if (pop) begin
            if (mq.size() == 0) m_udf = 1;
            else dec = mq.pop_front();
            if (dec) m_drop++;
            else m_pass++;
        end
        if (push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(1'b0);
                m_tail_ok = 1;
            end else begin
                m_ovf = 1;
                m_tail_ok = 0;
            end
        end
        gate = pop ? dec : m_cur_drop;
        if (pop) m_cur_drop = dec && !d.eop;
        else if (d.valid && d.eop) m_cur_drop = 0;
        m_out = d;
        if (gate) begin
            m_out.valid = 1'b0;
            m_out.sop   = 1'b0;
            m_out.eop   = 1'b0;
        end
        m_pulse = pop && dec;
    endtask

    task automatic compare_all();
        check("out", 64'(out_w), 64'(m_out));
        check("drop_pulse", 64'(drop_pulse), 64'(m_pulse));
        check("pass_count", 64'(pass_count), 64'(m_pass));
        check("drop_count", 64'(drop_count), 64'(m_drop));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("underflow", 64'(underflow), 64'(m_udf));
        if (drop_pulse) obs_pulses++;
        if (out_w.valid && out_w.sop) obs_sops++;
    endtask

    function automatic avln_st mk_word(input bit s, input bit e);
        avln_st w;
        w.valid = 1'b1;
        w.sop   = s;
        w.eop   = e;
        w.empty = 2'($urandom_range(0, 3));
        w.error = 1'($urandom_range(0, 1));
        w.data  = $urandom;
        return w;
    endfunction

    function automatic avln_st mk_idle();
        avln_st w;
        w = '0;
        w.data = $urandom;
        return w;
    endfunction

    task automatic set_delay(input int n);
        dline.delete();
        repeat (n) dline.push_back('0);
    endtask

    task automatic cycle(input avln_st w, input bit vv, input bit vd);
        avln_st d;
        dline.push_back(w);
        d = dline.pop_front();
        in_w = w;
        dly_w = d;
        verdict_valid = vv;
        verdict_drop = vd;
        model_step(w, vv, vd, d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic pkt(input int len, input int vpos, input bit vd);
        for (int i = 0; i < len; i++)
            cycle(mk_word(i == 0, i == len - 1), i == vpos, vd);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(mk_idle(), 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int delay);
        rst = 1'b1;
        in_w = '0;
        dly_w = '0;
        verdict_valid = 1'b0;
        verdict_drop = 1'b0;
        model_reset();
        set_delay(delay);
        obs_pulses = 0;
        obs_sops = 0;
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        // 1: pass, drop, pass through a 20-cycle fifo
        do_reset(20);
        pkt(4, 2, 1'b0);
        pkt(4, 2, 1'b1);
        pkt(4, 2, 1'b0);
        idle(25);
        check("t1_pass", 64'(pass_count), 64'd2);
        check("t1_drop", 64'(drop_count), 64'd1);
        check("t1_pulses", 64'(obs_pulses), 64'd1);
        check("t1_out_pkts", 64'(obs_sops), 64'd2);
        $display("t1 three packets: pass=%0d drop=%0d", pass_count, drop_count);

        // 2: stray verdict before any sop, then a packet with no verdict
        do_reset(8);
        cycle(mk_idle(), 1'b1, 1'b1);
        pkt(3, -1, 1'b0);
        idle(12);
        check("t2_pass", 64'(pass_count), 64'd1);
        check("t2_drop", 64'(drop_count), 64'd0);
        check("t2_out_pkts", 64'(obs_sops), 64'd1);
        $display("t2 no verdict: pass=%0d drop=%0d", pass_count, drop_count);

        // 3: overflow on the fifth sop, ignored verdict, underflow at fifth pop
        do_reset(30);
        for (int k = 0; k < 4; k++) pkt(2, -1, 1'b0);
        check("t3_no_ovf_yet", 64'(overflow), 64'd0);
        pkt(2, -1, 1'b0);
        check("t3_ovf", 64'(overflow), 64'd1);
        cycle(mk_idle(), 1'b1, 1'b1);
        idle(35);
        check("t3_udf", 64'(underflow), 64'd1);
        check("t3_pass", 64'(pass_count), 64'd5);
        check("t3_drop", 64'(drop_count), 64'd0);
        $display("t3 overflow/underflow: ovf=%0d udf=%0d pass=%0d", overflow, underflow, pass_count);

        // 4: verdict coinciding with head pop, then verdict coinciding with new sop
        do_reset(6);
        pkt(3, -1, 1'b0);
        idle(3);
        cycle(mk_idle(), 1'b1, 1'b1);
        idle(4);
        check("t4_bypass_drop", 64'(drop_count), 64'd1);
        pkt(2, -1, 1'b0);
        pkt(2, 0, 1'b1);
        idle(10);
        check("t4_drop", 64'(drop_count), 64'd2);
        check("t4_pass", 64'(pass_count), 64'd1);
        $display("t4 bypass and same-cycle mark: pass=%0d drop=%0d", pass_count, drop_count);

        // 5: back-to-back single-word packets, even ones dropped
        do_reset(3);
        for (int k = 0; k < 8; k++)
            cycle(mk_word(1'b1, 1'b1), k > 0, ((k - 1) % 2) == 0);
        cycle(mk_idle(), 1'b1, 1'b0);
        idle(6);
        check("t5_drop", 64'(drop_count), 64'd4);
        check("t5_pass", 64'(pass_count), 64'd4);
        check("t5_pulses", 64'(obs_pulses), 64'd4);
        check("t5_out_pkts", 64'(obs_sops), 64'd4);
        $display("t5 alternating 1-word: pass=%0d drop=%0d", pass_count, drop_count);

        // 6: reset in the middle of a dropped packet
        do_reset(4);
        pkt(6, 1, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_w.valid), 64'd0);
        check("t6_rst_drop", 64'(drop_count), 64'd0);
        check("t6_rst_pass", 64'(pass_count), 64'd0);
        do_reset(4);
        pkt(3, 1, 1'b0);
        idle(8);
        check("t6_pass", 64'(pass_count), 64'd1);
        check("t6_drop", 64'(drop_count), 64'd0);
        check("t6_out_pkts", 64'(obs_sops), 64'd1);
        $display("t6 mid-packet reset: pass=%0d drop=%0d", pass_count, drop_count);

        // Random traffic with random verdict pulses and fifo depths
        for (int seg = 0; seg < 4; seg++) begin
            do_reset($urandom_range(2, 12));
            for (int p = 0; p < 40; p++) begin
                int len;
                int gap;
                len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++)
                    cycle(mk_word(i == 0, i == len - 1), $urandom_range(0, 4) == 0,
                          1'($urandom_range(0, 1)));
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++)
                    cycle(mk_idle(), $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
            end
            idle(15);
            check("rnd_total", 64'(pass_count + drop_count), 64'(m_pass + m_drop));
            $display("random seg %0d: pass=%0d drop=%0d ovf=%0d udf=%0d",
                     seg, pass_count, drop_count, overflow, underflow);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
